// File: rtl/sid_dsm_pkg.sv
// Shared types and constants for the SID delta-sigma audio output stage.
package sid_dsm_pkg;

    localparam int DSM_DW = 8;

    // 16-bit Galois LFSR, taps 16,14,13,11, right-shifting form.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        MUTE    = 2'd0,
        RAMP_UP = 2'd1,
        RUN     = 2'd2,
        RAMP_DN = 2'd3
    } dsm_state_e;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/sid_dsm_out_if.sv
// Sample/enable inputs and bitstream/status outputs of the SID audio output stage.
interface sid_dsm_out_if
    import sid_dsm_pkg::*;
#(
    parameter int DW = DSM_DW
) ();

    logic [DW-1:0] sample;
    logic          sample_valid;
    logic          en;
    logic          dsm_out;
    logic          active;

    modport master (
        output sample,
        output sample_valid,
        output en,
        input  dsm_out,
        input  active
    );

    modport slave (
        input  sample,
        input  sample_valid,
        input  en,
        output dsm_out,
        output active
    );

endinterface

// File: rtl/sid_dsm_core.sv
// First-order delta-sigma modulator; SID_DSM_DITHER_EN adds a signed dither
// term and widens the accumulator.
module sid_dsm_core
    import sid_dsm_pkg::*;
#(
    parameter int DW = DSM_DW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mute_i,
    input  logic [DW-1:0]     x_i,
`ifdef SID_DSM_DITHER_EN
    input  logic signed [1:0] dither_i,
`endif
    output logic              dsm_out_o
);

`ifdef SID_DSM_DITHER_EN
    localparam logic signed [DW+1:0] FULL = (DW+2)'(1) << DW;

    logic signed [DW+1:0] acc_q, acc_d, sum;
    logic                 dsm_d;

    always_comb begin
        sum   = acc_q + $signed({2'b00, x_i}) + $signed({{DW{dither_i[1]}}, dither_i});
        dsm_d = (sum >= FULL);
        acc_d = dsm_d ? (sum - FULL) : sum;
        if (mute_i) begin
            acc_d = '0;
            dsm_d = 1'b0;
        end
    end
`else
    logic [DW-1:0] acc_q, acc_d;
    logic [DW:0]   sum;
    logic          dsm_d;

    // NOTE: every variable gets its value on every path before any override,
    // so this block stays purely combinational with no inferred latch.
    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, x_i};
        acc_d = sum[DW-1:0];
        dsm_d = sum[DW];
        if (mute_i) begin
            acc_d = '0;
            dsm_d = 1'b0;
        end
    end
`endif

    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            dsm_out_o <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            dsm_out_o <= dsm_d;
        end
    end

endmodule

// File: rtl/sid_dsm_out.sv
// SID audio output: sample hold, mute/soft-ramp FSM and delta-sigma modulator.
// Define SID_DSM_DITHER_EN to add LFSR first-difference dither.
module sid_dsm_out
    import sid_dsm_pkg::*;
#(
    parameter int DW         = DSM_DW,
    parameter int RAMP_SHIFT = 8
) (
    input  logic         clk,
    input  logic         rst,
    sid_dsm_out_if.slave bus
);

    localparam logic [DW-1:0] RAMP_MAX = {DW{1'b1}};

    dsm_state_e             state_q, state_d;
    logic [DW-1:0]          hold_q, hold_d;
    logic [DW-1:0]          ramp_q, ramp_d;
    logic [RAMP_SHIFT-1:0]  presc_q;
    logic                   tick;
    logic [DW-1:0]          x;

    assign tick   = &presc_q;
    assign hold_d = bus.sample_valid ? bus.sample : hold_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MUTE;
            hold_q  <= '0;
            ramp_q  <= '0;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            ramp_q  <= ramp_d;
            presc_q <= presc_q + 1'b1;
        end
    end

    // An en change wins over a coincident tick: direction flips, ramp is kept.
    always_comb begin
        state_d = state_q;
        ramp_d  = ramp_q;
        unique case (state_q)
            MUTE: begin
                ramp_d = '0;
                if (bus.en) state_d = RAMP_UP;
            end
            RAMP_UP: begin
                if (!bus.en) begin
                    state_d = RAMP_DN;
                end else if (tick) begin
                    if (ramp_q >= RAMP_MAX - 1'b1) begin
                        ramp_d  = RAMP_MAX;
                        state_d = RUN;
                    end else begin
                        ramp_d = ramp_q + 1'b1;
                    end
                end
            end
            RUN: begin
                ramp_d = RAMP_MAX;
                if (!bus.en) state_d = RAMP_DN;
            end
            RAMP_DN: begin
                if (bus.en) begin
                    state_d = RAMP_UP;
                end else if (tick) begin
                    if (ramp_q <= DW'(1)) begin
                        ramp_d  = '0;
                        state_d = MUTE;
                    end else begin
                        ramp_d = ramp_q - 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        x          = '0;
        bus.active = 1'b1;
        unique case (state_q)
            MUTE:             bus.active = 1'b0;
            RUN:              x = hold_q;
            RAMP_UP, RAMP_DN: x = DW'(((2*DW)'(hold_q) * (2*DW)'(ramp_q)) >> DW);
            default: ;
        endcase
    end

`ifdef SID_DSM_DITHER_EN
    logic [15:0]       lfsr_q;
    logic              lfsr_prev_q;
    logic signed [1:0] dither;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q      <= LFSR_SEED;
            lfsr_prev_q <= LFSR_SEED[0];
        end else begin
            lfsr_q      <= lfsr_next(lfsr_q);
            lfsr_prev_q <= lfsr_q[0];
        end
    end

    assign dither = (state_q == MUTE) ? 2'sd0
                  : ($signed({1'b0, lfsr_q[0]}) - $signed({1'b0, lfsr_prev_q}));
`endif

    sid_dsm_core #(
        .DW(DW)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .mute_i    (state_q == MUTE),
        .x_i       (x),
`ifdef SID_DSM_DITHER_EN
        .dither_i  (dither),
`endif
        .dsm_out_o (bus.dsm_out)
    );

endmodule

// File: tb/tb_sid_dsm_out.sv
// Directed bench for sid_dsm_out: mute, ramp timing, RUN density, latency, reset.
module tb_sid_dsm_out;
    import sid_dsm_pkg::*;

    logic clk;
    logic rst;

    sid_dsm_out_if #(.DW(8)) bus ();

    sid_dsm_out #(
        .DW         (8),
        .RAMP_SHIFT (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #100 clk = ~clk;
    end

    int         errors = 0;
    int         checks = 0;
    int         slot   = 0;
    bit         auto_strobe = 1'b1;
    bit         manual_strobe = 1'b0;
    logic [7:0] smp = 8'h00;

    // One clock: drive inputs, take the edge, sample outputs 1 time unit later.
    task automatic step();
        bus.sample       = smp;
        bus.sample_valid = manual_strobe || (auto_strobe && (slot == 4));
        @(posedge clk);
        #1;
        manual_strobe = 1'b0;
        slot = (slot == 5) ? 0 : slot + 1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic count_ones(input int n, output int ones);
        ones = 0;
        for (int i = 0; i < n; i++) begin
            step();
            ones += int'(bus.dsm_out);
        end
    endtask

    task automatic wait_run(output int n);
        n = 0;
        while (dut.state_q != RUN && n < 2000) begin
            step();
            n++;
        end
    endtask

    initial begin
        int ones;
        int act;
        int n;
        int trans;
        logic prev;

        rst              = 1'b1;
        bus.en           = 1'b0;
        bus.sample       = '0;
        bus.sample_valid = 1'b0;
        smp              = 8'h80;
        repeat (3) step();
        check("rst_dsm_out", bus.dsm_out, 0);
        check("rst_active", bus.active, 0);
        rst = 1'b0;

        // en=0 with a live 0x80 stream stays silent and inactive.
        ones = 0;
        act  = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            ones += int'(bus.dsm_out);
            act  += int'(bus.active);
        end
        check("mute_ones", ones, 0);
        check("mute_active", act, 0);

        // Ramp up: 255 ticks of 4 clocks plus up to one partial period.
        bus.en = 1'b1;
        step();
        check("active_leaving_mute", bus.active, 1);
        wait_run(n);
        check_range("ramp_up_cycles", n, 1016, 1024);

        // x=0x80 in RUN toggles every cycle.
        trans = 0;
        ones  = 0;
        step();
        prev = bus.dsm_out;
        ones += int'(prev);
        for (int i = 0; i < 15; i++) begin
            step();
            if (bus.dsm_out != prev) trans++;
            prev = bus.dsm_out;
            ones += int'(prev);
        end
        check("run80_transitions", trans, 15);
        check("run80_ones", ones, 8);
        check("run_active", bus.active, 1);

        smp = 8'h40;
        repeat (20) step();
        count_ones(256, ones);
        check("run40_density", ones, 64);

        smp = 8'h00;
        repeat (20) step();
        count_ones(256, ones);
        check("run00_density", ones, 0);

        smp = 8'hFF;
        repeat (20) step();
        count_ones(256, ones);
        check("runFF_density", ones, 255);

        // Latency: single strobe 0x00 -> 0xFF at edge t.
        smp = 8'h00;
        repeat (20) step();
        auto_strobe   = 1'b0;
        smp           = 8'hFF;
        manual_strobe = 1'b1;
        step();
        check("lat_not_early", bus.dsm_out, 0);
        n = 0;
        while (bus.dsm_out == 1'b0 && n < 4) begin
            step();
            n++;
        end
        check_range("lat_first_one", n, 1, 2);
        auto_strobe = 1'b1;

        // en dropped at ramp=100 during RAMP_UP.
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.en = 1'b1;
        n = 0;
        while (dut.ramp_q != 8'd100 && n < 1000) begin
            step();
            n++;
        end
        check("ramp_reached_100", dut.ramp_q, 100);
        bus.en = 1'b0;
        step();
        check("rampdn_start_ramp", dut.ramp_q, 100);
        check("rampdn_active", bus.active, 1);
        n = 0;
        while (bus.active == 1'b1 && n < 600) begin
            step();
            n++;
        end
        check_range("rampdn_cycles", n, 396, 401);
        check("mute_state", dut.state_q, MUTE);
        count_ones(20, ones);
        check("mute_after_ramp_ones", ones, 0);

        // Reset for one cycle while in RUN.
        bus.en = 1'b1;
        wait_run(n);
        check_range("ramp_up_cycles_2", n, 1016, 1024);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_run_dsm_out", bus.dsm_out, 0);
        check("rst_run_active", bus.active, 0);
        check("rst_run_state", dut.state_q, MUTE);
        check("rst_run_ramp", dut.ramp_q, 0);
        check("rst_run_hold", dut.hold_q, 0);
        check("rst_run_presc", dut.presc_q, 0);
`ifdef SID_DSM_DITHER_EN
        check("rst_run_lfsr", dut.lfsr_q, 32'h0000ACE1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
